// File: rtl/vipitc_hv_position_counter_if.sv
// rtl/vipitc_hv_position_counter_if.sv - control and raster decode signals of the h/v position counter
interface vipitc_hv_position_counter_if #(
   parameter int H_WIDTH = 12,
   parameter int V_WIDTH = 11
);
   logic               sclr;
   logic               count_sample;
   logic               frame_ready;
   logic               sample_valid;
   logic [H_WIDTH-1:0] h_pos;
   logic [V_WIDTH-1:0] v_pos;
   logic               active_video;
   logic               h_sync;
   logic               v_sync;
   logic               start_of_line;
   logic               start_of_frame;
   logic               frame_wait;

   modport master (
      output sclr, count_sample, frame_ready,
      input  sample_valid, h_pos, v_pos, active_video, h_sync, v_sync,
             start_of_line, start_of_frame, frame_wait
   );

   modport slave (
      input  sclr, count_sample, frame_ready,
      output sample_valid, h_pos, v_pos, active_video, h_sync, v_sync,
             start_of_line, start_of_frame, frame_wait
   );
endinterface

// File: rtl/vipitc_hv_position_counter.sv
// rtl/vipitc_hv_position_counter.sv - raster h/v position generator with registered sync/active decode
// Optional frame lock (WAIT state gated by frame_ready) enabled by VIPITC_HV_FRAME_LOCK_EN.
module vipitc_hv_position_counter #(
   parameter int H_ACTIVE        = 1920,
   parameter int H_FRONT         = 88,
   parameter int H_SYNC          = 44,
   parameter int H_BACK          = 148,
   parameter int V_ACTIVE        = 1080,
   parameter int V_FRONT         = 4,
   parameter int V_SYNC          = 5,
   parameter int V_BACK          = 36,
   parameter int H_WIDTH         = 12,
   parameter int V_WIDTH         = 11,
   parameter int SYNC_ACTIVE_LOW = 0
) (
   input logic clk,
   input logic rst,
   vipitc_hv_position_counter_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [H_WIDTH-1:0] H_LAST     = H_WIDTH'(H_TOTAL - 1);
   localparam logic [H_WIDTH-1:0] H_ACT_END  = H_WIDTH'(H_ACTIVE);
   localparam logic [H_WIDTH-1:0] H_SYNC_BEG = H_WIDTH'(H_ACTIVE + H_FRONT);
   localparam logic [H_WIDTH-1:0] H_SYNC_END = H_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [V_WIDTH-1:0] V_LAST     = V_WIDTH'(V_TOTAL - 1);
   localparam logic [V_WIDTH-1:0] V_ACT_END  = V_WIDTH'(V_ACTIVE);
   localparam logic [V_WIDTH-1:0] V_SYNC_BEG = V_WIDTH'(V_ACTIVE + V_FRONT);
   localparam logic [V_WIDTH-1:0] V_SYNC_END = V_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic               SYNC_OFF   = (SYNC_ACTIVE_LOW != 0);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]         state;
   logic [H_WIDTH-1:0] hc;
   logic [V_WIDTH-1:0] vc;
   logic               accept;
   logic               frame_last;

   logic               sample_valid_q;
   logic [H_WIDTH-1:0] h_pos_q;
   logic [V_WIDTH-1:0] v_pos_q;
   logic               active_video_q;
   logic               h_sync_q;
   logic               v_sync_q;
   logic               start_of_line_q;
   logic               start_of_frame_q;

   assign accept     = bus.count_sample && !bus.sclr && (state == ST_RUN);
   assign frame_last = (hc == H_LAST) && (vc == V_LAST);

`ifdef VIPITC_HV_FRAME_LOCK_EN
   // A frame only rolls straight into the next if frame_ready is seen on its last sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_WAIT;
      end else if (bus.sclr) begin
         state <= ST_WAIT;
      end else if (state == ST_WAIT) begin
         if (bus.frame_ready) state <= ST_RUN;
      end else if (accept && frame_last && !bus.frame_ready) begin
         state <= ST_WAIT;
      end
   end
   assign bus.frame_wait = (state == ST_WAIT);
`else
   logic unused_frame_ready;
   assign unused_frame_ready = bus.frame_ready;
   assign state              = ST_RUN;
   assign bus.frame_wait     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc               <= '0;
         vc               <= '0;
         sample_valid_q   <= 1'b0;
         h_pos_q          <= '0;
         v_pos_q          <= '0;
         active_video_q   <= 1'b0;
         h_sync_q         <= SYNC_OFF;
         v_sync_q         <= SYNC_OFF;
         start_of_line_q  <= 1'b0;
         start_of_frame_q <= 1'b0;
      end else if (bus.sclr) begin
         hc               <= '0;
         vc               <= '0;
         sample_valid_q   <= 1'b0;
         h_pos_q          <= '0;
         v_pos_q          <= '0;
         active_video_q   <= 1'b0;
         h_sync_q         <= SYNC_OFF;
         v_sync_q         <= SYNC_OFF;
         start_of_line_q  <= 1'b0;
         start_of_frame_q <= 1'b0;
      end else begin
         // Strobe-qualified flags are single-cycle; everything else holds between strobes.
         sample_valid_q   <= accept;
         start_of_line_q  <= accept && (hc == '0);
         start_of_frame_q <= accept && (hc == '0) && (vc == '0);
         if (accept) begin
            h_pos_q        <= hc;
            v_pos_q        <= vc;
            active_video_q <= (hc < H_ACT_END) && (vc < V_ACT_END);
            h_sync_q       <= ((hc >= H_SYNC_BEG) && (hc < H_SYNC_END)) ^ SYNC_OFF;
            v_sync_q       <= ((vc >= V_SYNC_BEG) && (vc < V_SYNC_END)) ^ SYNC_OFF;
            if (hc == H_LAST) begin
               hc <= '0;
               vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
               hc <= hc + 1'b1;
            end
         end
      end
   end

   assign bus.sample_valid   = sample_valid_q;
   assign bus.h_pos          = h_pos_q;
   assign bus.v_pos          = v_pos_q;
   assign bus.active_video   = active_video_q;
   assign bus.h_sync         = h_sync_q;
   assign bus.v_sync         = v_sync_q;
   assign bus.start_of_line  = start_of_line_q;
   assign bus.start_of_frame = start_of_frame_q;
endmodule
